// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised RAM controller.
package ram_pkg;

    // Controller states: CLEAR sweeps zeros into the array, IDLE serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Read-during-write selection: which word a write returns on rvalid.
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Expands one byte enable into the 8-bit lane mask used by the merge.
    function automatic logic [7:0] byte_lane_mask(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/ram_ctrl_p_if.sv
// Request/response bus between the CPU-side glue and the RAM controller.
interface ram_ctrl_p_if #(
    parameter int DW = 16,
    parameter int AW = 9
);
    logic            req;
    logic            WE;
    logic [DW/8-1:0] be;
    logic [AW-1:0]   ad;
    logic [DW-1:0]   in;
    logic            clr;
    logic            ready;
    logic [DW-1:0]   out;
    logic            rvalid;
    logic            err;
    logic            busy;

    modport master (
        output req, WE, be, ad, in, clr,
        input  ready, out, rvalid, err, busy
    );

    modport slave (
        input  req, WE, be, ad, in, clr,
        output ready, out, rvalid, err, busy
    );
endinterface

// File: rtl/ram_core.sv
// DEPTH x DW single-port array: byte-masked synchronous write, registered
// read with a selectable old-word / merged-word return on writes.
module ram_core
    import ram_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 9,
    parameter int DEPTH   = 512,
    parameter int RD_MODE = RD_FIRST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic            rzero,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] old_word;
    logic [DW-1:0] mask;
    logic [DW-1:0] merged;

    // Build the byte mask and the post-write word seen by write-first reads.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        mask = '0;
        for (int i = 0; i < DW/8; i++) begin
            mask[8*i +: 8] = byte_lane_mask(be[i]);
        end
        old_word = mem[addr];
        merged   = (old_word & ~mask) | (wdata & mask);
    end

    // Byte-masked write into the array.
    // NOTE: the array has no reset (it maps onto RAM macros); the controller's clear sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DW/8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register: holds its value between accesses, forced to 0 for rejected addresses.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            if (rzero) begin
                rdata <= '0;
            end else if (we && (RD_MODE == WR_FIRST)) begin
                rdata <= merged;
            end else begin
                rdata <= old_word;
            end
        end
    end

endmodule

// File: rtl/ram_ctrl_p.sv
// RAM controller: clear sweeper FSM, request handshake, range check and
// response strobes around a single ram_core instance.
module ram_ctrl_p
    import ram_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 9,
    parameter int DEPTH   = 512,
    parameter int RD_MODE = RD_FIRST
) (
    input  logic          clk,
    input  logic          rst,
    ram_ctrl_p_if.slave   bus
);

    // The counter is one bit wider than the address so DEPTH == 2**AW ends cleanly.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW:0]     cnt;
    logic            accept;
    logic            oor;
    logic            ready_c;
    logic            busy_c;
    logic            rvalid_q;
    logic            err_q;
    logic            core_we;
    logic            core_re;
    logic [DW/8-1:0] core_be;
    logic [AW-1:0]   core_addr;
    logic [DW-1:0]   core_wdata;
    logic [DW-1:0]   core_rdata;

    // Next-state logic, handshake outputs and the array port mux.
    always_comb begin
        state_nxt  = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        accept     = 1'b0;
        oor        = ({1'b0, bus.ad} >= DEPTH_W);
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_be    = bus.be;
        core_addr  = bus.ad;
        core_wdata = bus.in;
        case (state)
            CLEAR: begin
                busy_c     = 1'b1;
                core_we    = 1'b1;
                core_be    = '1;
                core_addr  = cnt[AW-1:0];
                core_wdata = '0;
                if (cnt == LAST_W) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                ready_c = 1'b1;
                if (bus.clr) begin
                    state_nxt = CLEAR;
                end else begin
                    accept  = bus.req;
                    core_re = bus.req;
                    core_we = bus.req & bus.WE & ~oor;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // State register; reset restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep counter: advances through CLEAR, rewinds when a clear is commanded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + (AW+1)'(1);
        end else if (bus.clr) begin
            cnt <= '0;
        end
    end

    // One-cycle response strobes for every accepted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= accept;
            err_q    <= accept & oor;
        end
    end

    ram_core #(
        .DW      (DW),
        .AW      (AW),
        .DEPTH   (DEPTH),
        .RD_MODE (RD_MODE)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we),
        .re    (core_re),
        .rzero (oor),
        .be    (core_be),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    assign bus.ready  = ready_c;
    assign bus.busy   = busy_c;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.out    = core_rdata;

endmodule

// File: tb/tb_ram_ctrl_p.sv
// Bench for ram_ctrl_p: two instances share one stimulus stream, one with
// default geometry and read-first, one with DEPTH=300 and write-first.
module tb_ram_ctrl_p;

    typedef struct {
        logic [15:0] d;
        logic        e;
        bit          chk_d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_ctrl_p_if #(.DW(16), .AW(9)) bus0 ();
    ram_ctrl_p_if #(.DW(16), .AW(9)) bus1 ();

    assign bus1.req = bus0.req;
    assign bus1.WE  = bus0.WE;
    assign bus1.be  = bus0.be;
    assign bus1.ad  = bus0.ad;
    assign bus1.in  = bus0.in;
    assign bus1.clr = bus0.clr;

    ram_ctrl_p #(.DW(16), .AW(9), .DEPTH(512), .RD_MODE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ram_ctrl_p #(.DW(16), .AW(9), .DEPTH(300), .RD_MODE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] m0 [512];
    logic [15:0] m1 [300];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 512; i++) m0[i] = 16'h0000;
        for (int i = 0; i < 300; i++) m1[i] = 16'h0000;
    endtask

    // Model: dut0 is 512 deep, read-first; dut1 is 300 deep, write-first.
    task automatic push_exp(input bit we, input logic [1:0] b, input logic [8:0] a, input logic [15:0] d);
        exp_t        e;
        logic [15:0] msk;
        logic [15:0] old;
        logic [15:0] mrg;
        msk = {{8{b[1]}}, {8{b[0]}}};

        old     = m0[a];
        mrg     = (old & ~msk) | (d & msk);
        e.d     = old;
        e.e     = 1'b0;
        e.chk_d = 1'b1;
        q0.push_back(e);
        if (we) m0[a] = mrg;

        if (a >= 9'd300) begin
            e.d     = 16'h0000;
            e.e     = 1'b1;
            e.chk_d = !we;
        end else begin
            old     = m1[a];
            mrg     = (old & ~msk) | (d & msk);
            e.d     = we ? mrg : old;
            e.e     = 1'b0;
            e.chk_d = 1'b1;
            if (we) m1[a] = mrg;
        end
        q1.push_back(e);
    endtask

    task automatic sb_check(input int k, input logic rv, input logic er, input logic [15:0] d);
        exp_t e;
        bit   empty;
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (rv) begin
            if (empty) begin
                check($sformatf("rvalid_unexpected%0d", k), rv, 1'b0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (e.chk_d) check($sformatf("out%0d", k), d, e.d);
                check($sformatf("err%0d", k), er, e.e);
            end
        end else if (er) begin
            check($sformatf("err_without_rvalid%0d", k), er, 1'b0);
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb_check(0, bus0.rvalid, bus0.err, bus0.out);
            sb_check(1, bus1.rvalid, bus1.err, bus1.out);
        end
    end

    task automatic access(input bit we, input logic [1:0] b, input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        check("ready_at_req", {bus0.ready, bus1.ready}, 2'b11);
        bus0.req = 1'b1;
        bus0.WE  = we;
        bus0.be  = b;
        bus0.ad  = a;
        bus0.in  = d;
        push_exp(we, b, a, d);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus0.req = 1'b0;
        bus0.clr = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Call just after the edge that starts a sweep (or right after reset release).
    task automatic sweep_len(input string tag);
        int c0;
        int c1;
        c0 = -1;
        c1 = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (c0 < 0 && !bus0.busy) c0 = cyc;
            if (c1 < 0 && !bus1.busy) c1 = cyc;
            if (c0 >= 0 && c1 >= 0) break;
        end
        check({tag, "_len0"}, c0, 512);
        check({tag, "_len1"}, c1, 300);
        check({tag, "_ready"}, {bus0.ready, bus1.ready}, 2'b11);
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_out0"}, bus0.out, 16'h0000);
        check({tag, "_out1"}, bus1.out, 16'h0000);
        check({tag, "_rvalid"}, {bus0.rvalid, bus1.rvalid}, 2'b00);
        check({tag, "_err"}, {bus0.err, bus1.err}, 2'b00);
        check({tag, "_busy"}, {bus0.busy, bus1.busy}, 2'b11);
        check({tag, "_ready"}, {bus0.ready, bus1.ready}, 2'b00);
    endtask

    initial begin
        bus0.req = 1'b0;
        bus0.WE  = 1'b0;
        bus0.be  = 2'b00;
        bus0.ad  = '0;
        bus0.in  = '0;
        bus0.clr = 1'b0;
        clear_models();

        // Reset state and boot sweep length.
        #2;
        check_rst_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sweep_len("boot");

        // Top-of-array read after boot (out of range for the 300-deep instance).
        access(1'b0, 2'b00, 9'h1FF, 16'h0000);

        // Full-word writes then back-to-back reads.
        access(1'b1, 2'b11, 9'd0, 16'h000F);
        access(1'b1, 2'b11, 9'd1, 16'h00F0);
        access(1'b0, 2'b00, 9'd0, 16'h0000);
        access(1'b0, 2'b00, 9'd1, 16'h0000);

        // Partial byte write and a be=0 no-op write.
        access(1'b1, 2'b10, 9'd0, 16'hAB55);
        access(1'b0, 2'b00, 9'd0, 16'h0000);
        access(1'b1, 2'b00, 9'd0, 16'hFFFF);
        access(1'b0, 2'b00, 9'd0, 16'h0000);

        // Read-during-write return word.
        access(1'b1, 2'b11, 9'd2, 16'h1234);
        access(1'b0, 2'b00, 9'd2, 16'h0000);

        // Range boundary around DEPTH=300.
        access(1'b1, 2'b11, 9'd299, 16'h5A5A);
        access(1'b0, 2'b00, 9'd300, 16'h0000);
        access(1'b1, 2'b11, 9'd310, 16'hFFFF);
        access(1'b0, 2'b00, 9'd299, 16'h0000);
        access(1'b0, 2'b00, 9'd310, 16'h0000);

        // Mixed random traffic.
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   9'($urandom_range(0, 511)), 16'($urandom));
        end
        idle(3);
        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);

        // Clear command beats a simultaneous request.
        @(negedge clk);
        bus0.clr = 1'b1;
        bus0.req = 1'b1;
        bus0.WE  = 1'b0;
        bus0.ad  = 9'd1;
        @(posedge clk);
        #1;
        bus0.clr = 1'b0;
        bus0.req = 1'b0;
        check("clr_ready_drop", {bus0.ready, bus1.ready}, 2'b00);
        sweep_len("clr");
        clear_models();
        access(1'b0, 2'b00, 9'd1, 16'h0000);
        access(1'b0, 2'b00, 9'd2, 16'h0000);

        // Leave a non-zero word on out, then reset in the middle of a sweep.
        access(1'b1, 2'b11, 9'd3, 16'hBEEF);
        access(1'b0, 2'b00, 9'd3, 16'h0000);
        idle(3);
        check("drain0b", q0.size(), 0);
        check("drain1b", q1.size(), 0);
        @(negedge clk);
        bus0.clr = 1'b1;
        @(posedge clk);
        #1;
        bus0.clr = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        check("out_held0", bus0.out, 16'hBEEF);
        check("out_held1", bus1.out, 16'hBEEF);
        rst = 1'b1;
        #1;
        check_rst_outputs("midsweep_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sweep_len("rerun");
        clear_models();
        access(1'b0, 2'b00, 9'd3, 16'h0000);
        idle(3);
        check("drain0c", q0.size(), 0);
        check("drain1c", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
